// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: default width plus binary<->Gray helpers.
// The helpers work at the default width GRAY_W.
package gray_pkg;

    localparam int GRAY_W = 4;

    function automatic logic [GRAY_W-1:0] b2g(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_W-1:0] g2b(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/b2g_converter.sv
// Combinational N-bit binary-to-Gray encoder.
module b2g_converter #(
    parameter int N = 4
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/b2g_counter.sv
// N-bit up/down binary counter with a registered Gray copy and a wrap pulse.
// Define B2G_LOAD_EN to add the parallel load port (load/load_val).
module b2g_counter
    import gray_pkg::*;
#(
    parameter int N = GRAY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
`ifdef B2G_LOAD_EN
    input  logic         load,
    input  logic [N-1:0] load_val,
`endif
    output logic [N-1:0] bin,
    output logic [N-1:0] gray,
    output logic         wrap
);

    logic [N-1:0] bin_next;
    logic [N-1:0] gray_next;
    logic         wrap_next;

    always_comb begin
        bin_next  = bin;
        wrap_next = 1'b0;
`ifdef B2G_LOAD_EN
        if (load) begin
            bin_next = load_val;
        end else
`endif
        if (en) begin
            if (up) begin
                bin_next  = bin + N'(1);
                wrap_next = &bin;
            end else begin
                bin_next  = bin - N'(1);
                wrap_next = ~|bin;
            end
        end
    end

    // Gray is encoded from the next binary value so both registers move together.
    b2g_converter #(.N(N)) u_enc (
        .bin  (bin_next),
        .gray (gray_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_b2g_counter.sv
// Directed bench for b2g_counter (N=4) with a Gray-to-binary loopback check.
module tb_b2g_counter;
    import gray_pkg::*;

    localparam int N = 4;
    localparam logic [3:0] GTAB [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                         4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    logic         clk = 1'b0;
    logic         rst, en, up;
`ifdef B2G_LOAD_EN
    logic         load;
    logic [N-1:0] load_val;
`endif
    logic [N-1:0] bin, gray;
    logic         wrap;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    b2g_counter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
`ifdef B2G_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .bin      (bin),
        .gray     (gray),
        .wrap     (wrap)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eb, input logic [3:0] eg,
                             input logic ew);
        check({tag, ".bin"},  32'(bin),  32'(eb));
        check({tag, ".gray"}, 32'(gray), 32'(eg));
        check({tag, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    initial begin
        logic [3:0] prev_gray;
        logic [3:0] mbin;
        logic       mwrap;

        rst = 1'b1;
        en  = 1'b1;
        up  = 1'b1;
`ifdef B2G_LOAD_EN
        load     = 1'b0;
        load_val = '0;
`endif
        step();
        check_all("rst1", 4'd0, 4'h0, 1'b0);
        step();
        check_all("rst2", 4'd0, 4'h0, 1'b0);
        rst = 1'b0;

        // Up count through the 15->0 wrap.
        prev_gray = gray;
        for (int i = 1; i <= 17; i++) begin
            step();
            check_all($sformatf("up%0d", i), 4'(i % 16), GTAB[i % 16], (i == 16));
            check($sformatf("up%0d.onebit", i), 32'($countones(gray ^ prev_gray)), 32'd1);
            prev_gray = gray;
        end

        // Down from 1 to 0, then the 0->15 wrap.
        up = 1'b0;
        step();
        check_all("dn0", 4'd0, 4'h0, 1'b0);
        step();
        check_all("dnwrap", 4'd15, 4'h8, 1'b1);
        check("dnwrap.onebit", 32'($countones(gray ^ 4'h0)), 32'd1);
        step();
        check_all("dn14", 4'd14, 4'h9, 1'b0);

        // Hold and direction toggle.
        rst = 1'b1;
        step();
        check_all("rst3", 4'd0, 4'h0, 1'b0);
        rst = 1'b0;
        up  = 1'b1;
        en  = 1'b1; step(); check_all("hold1", 4'd1, 4'h1, 1'b0);
        en  = 1'b1; step(); check_all("hold2", 4'd2, 4'h3, 1'b0);
        en  = 1'b0; step(); check_all("hold3", 4'd2, 4'h3, 1'b0);
        en  = 1'b0; step(); check_all("hold4", 4'd2, 4'h3, 1'b0);
        en  = 1'b1; step(); check_all("hold5", 4'd3, 4'h2, 1'b0);
        up  = 1'b0; step(); check_all("toggle", 4'd2, 4'h3, 1'b0);

        // Reset on an edge that would otherwise wrap downward.
        step();
        step();
        check_all("at0", 4'd0, 4'h0, 1'b0);
        rst = 1'b1;
        step();
        check_all("rstwrap", 4'd0, 4'h0, 1'b0);
        rst = 1'b0;

        // Random en/up with loopback through g2b.
        mbin = 4'd0;
        for (int i = 0; i < 64; i++) begin
            en = 1'($urandom_range(0, 1));
            up = 1'($urandom_range(0, 1));
            mwrap = 1'b0;
            if (en) begin
                if (up) begin
                    mwrap = (mbin == 4'd15);
                    mbin  = mbin + 4'd1;
                end else begin
                    mwrap = (mbin == 4'd0);
                    mbin  = mbin - 4'd1;
                end
            end
            step();
            check($sformatf("loop%0d.g2b", i), 32'(g2b(gray)), 32'(bin));
            check($sformatf("loop%0d.bin", i), 32'(bin), 32'(mbin));
            check($sformatf("loop%0d.wrap", i), 32'(wrap), 32'(mwrap));
        end

`ifdef B2G_LOAD_EN
        en = 1'b1;
        up = 1'b1;
        load = 1'b1; load_val = 4'd5;
        step();
        check_all("load5", 4'd5, 4'h7, 1'b0);
        load_val = 4'd15;
        step();
        check_all("load15", 4'd15, 4'h8, 1'b0);
        step();
        check_all("loadnowrap", 4'd15, 4'h8, 1'b0);
        load = 1'b0;
        step();
        check_all("loadwrap", 4'd0, 4'h0, 1'b1);
        load = 1'b1; load_val = 4'd9; rst = 1'b1;
        step();
        check_all("rstload", 4'd0, 4'h0, 1'b0);
        load = 1'b0; rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
